// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the single-port memory responder.
package mem_responder_pkg;

  localparam int unsigned DataW      = 16;
  localparam int unsigned DefaultLat = 4;
  localparam int unsigned CntW       = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic {
    PortI = 1'b0,
    PortD = 1'b1
  } port_e;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word array with registered read and write enable; contents not reset.
module mem_responder_ram #(
  parameter int unsigned AddrW = 16,
  parameter int unsigned DataW = 16
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [DataW-1:0] wdata,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency responder serving instruction fetch and data ports one access at a time.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LAT    = DefaultLat
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_abort,
  output logic              i_ack,
  output logic [DataW-1:0]  i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DataW-1:0]  d_wdata,
  output logic              d_ack,
  output logic [DataW-1:0]  d_rdata,
  output logic              busy
);

  localparam logic [CntW-1:0] CntLoad = CntW'(LAT - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  port_e             port_q, port_d;
  port_e             last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic [DataW-1:0]  i_rdata_q, i_rdata_d;
  logic [DataW-1:0]  d_rdata_q, d_rdata_d;

  logic             abort_hit, access, ram_en, show_i, show_d;
  logic [DataW-1:0] ram_rdata;

  assign abort_hit = i_abort && (port_q == PortI) && (state_q != StIdle);
  assign access    = (state_q == StBusy) && (cnt_q == '0) && !abort_hit;
  // A reset on the access edge must keep a pending write out of the array.
  assign ram_en    = access && !rst;
  // Read data is live from the array register during RESP and latched on the way out.
  assign show_i    = (state_q == StResp) && (port_q == PortI) && !i_abort;
  assign show_d    = (state_q == StResp) && (port_q == PortD) && !we_q;

  mem_responder_ram #(
    .AddrW(ADDR_W),
    .DataW(DataW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (we_q),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      port_q       <= PortI;
      last_grant_q <= PortI;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = show_i ? ram_rdata : i_rdata_q;
    d_rdata_d    = show_d ? ram_rdata : d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          if (d_req && (!i_req || (last_grant_q != PortD))) begin
            port_d  = PortD;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            port_d  = PortI;
            we_d    = 1'b0;
            addr_d  = i_addr;
          end
          last_grant_d = port_d;
          cnt_d        = CntLoad;
          state_d      = StBusy;
        end
      end
      StBusy: begin
        if (abort_hit) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    i_ack   = show_i;
    d_ack   = (state_q == StResp) && (port_q == PortD);
    i_rdata = i_rdata_d;
    d_rdata = d_rdata_d;
    busy    = (state_q != StIdle);
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, random traffic against a word-array model,
// and hand-built sequences for arbitration, abort, reset and minimum latency.
module tb_mem_responder;

  localparam int Lat = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_abort, i_ack, d_req, d_we, d_ack, busy;
  logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;

  logic        l1_i_req, l1_i_abort, l1_i_ack, l1_d_req, l1_d_we, l1_d_ack, l1_busy;
  logic [15:0] l1_i_addr, l1_i_rdata, l1_d_addr, l1_d_wdata, l1_d_rdata;

  int n_cmp = 0;
  int n_fail = 0;
  int both_cnt = 0;
  int i_ack_cnt = 0;
  int d_ack_cnt = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(16), .LAT(Lat)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .d_rdata(d_rdata), .busy(busy)
  );

  mem_responder #(.ADDR_W(16), .LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(l1_i_req), .i_addr(l1_i_addr), .i_abort(l1_i_abort), .i_ack(l1_i_ack),
    .i_rdata(l1_i_rdata), .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr),
    .d_wdata(l1_d_wdata), .d_ack(l1_d_ack), .d_rdata(l1_d_rdata), .busy(l1_busy)
  );

  always @(negedge clk) begin
    if (i_ack && d_ack) both_cnt++;
    if (i_ack) i_ack_cnt++;
    if (d_ack) d_ack_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1. Inputs are scrambled after capture; they must not matter.
  task automatic access(input bit is_d, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp, input bit abort,
                        input string tag);
    int n;
    logic [15:0] got;
    n = 0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    i_abort = abort;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        i_abort = abort && is_d;
        i_addr  = ~addr;
        d_addr  = ~addr;
        d_wdata = ~wdata;
        if (is_d) d_we = ~we;
      end
      if (n == 3) i_abort = 1'b0;
    end while (!(is_d ? d_ack : i_ack) && n < 40);
    got = is_d ? d_rdata : i_rdata;
    check({tag, " latency"}, n, Lat + 2);
    check({tag, " rdata"}, got, exp);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; i_abort = 1'b0;
    @(negedge clk);
    check({tag, " ack pulse"}, is_d ? d_ack : i_ack, 1'b0);
    check({tag, " busy low"}, busy, 1'b0);
    check({tag, " rdata held"}, is_d ? d_rdata : i_rdata, exp);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[10];
  logic [15:0] mdl[8];
  logic [15:0] mi, md, w;
  bit          isd, wr, ab, last_d, exp_d;
  int          n, a, ic, dc;

  initial begin
    vecs[0] = '{1, 1, 16'h0100, 16'hBEEF, 16'h0000};
    vecs[1] = '{1, 0, 16'h0100, 16'h0000, 16'hBEEF};
    vecs[2] = '{1, 1, 16'h0010, 16'hA5C3, 16'hBEEF};
    vecs[3] = '{1, 0, 16'h0010, 16'h0000, 16'hA5C3};
    vecs[4] = '{0, 0, 16'h0010, 16'h0000, 16'hA5C3};
    vecs[5] = '{1, 1, 16'h0020, 16'h9999, 16'hA5C3};
    vecs[6] = '{1, 1, 16'h1234, 16'hC0DE, 16'hA5C3};
    vecs[7] = '{1, 1, 16'h5678, 16'hF00D, 16'hA5C3};
    vecs[8] = '{1, 1, 16'h0030, 16'h2222, 16'hA5C3};
    vecs[9] = '{0, 0, 16'h0100, 16'h0000, 16'hBEEF};

    rst = 1'b1;
    i_req = 0; i_abort = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    l1_i_req = 0; l1_i_abort = 0; l1_i_addr = 0;
    l1_d_req = 0; l1_d_we = 0; l1_d_addr = 0; l1_d_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset i_ack", i_ack, 0);
    check("reset d_ack", d_ack, 0);
    check("reset i_rdata", i_rdata, 0);
    check("reset d_rdata", d_rdata, 0);
    check("reset busy", busy, 0);
    check("reset lat1 busy", l1_busy, 0);
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++)
      access(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp, 1'b0,
             $sformatf("vec%0d", v));

    // Random traffic over eight words, with i_abort sprinkled where it must be ignored.
    mi = 16'hBEEF; md = 16'hA5C3;
    for (int j = 0; j < 8; j++) begin
      w = 16'($urandom);
      access(1, 1, 16'(16'h0200 + j), w, md, 1'b0, "rnd_pre");
      mdl[j] = w;
    end
    for (int j = 0; j < 32; j++) begin
      isd = 1'($urandom_range(0, 1));
      wr  = isd && 1'($urandom_range(0, 1));
      ab  = 1'($urandom_range(0, 1));
      a   = int'($urandom_range(0, 7));
      w   = 16'($urandom);
      if (wr) begin
        access(1, 1, 16'(16'h0200 + a), w, md, ab, $sformatf("rnd%0d wr", j));
        mdl[a] = w;
      end else if (isd) begin
        md = mdl[a];
        access(1, 0, 16'(16'h0200 + a), w, md, ab, $sformatf("rnd%0d rd_d", j));
      end else begin
        mi = mdl[a];
        access(0, 0, 16'(16'h0200 + a), w, mi, ab, $sformatf("rnd%0d rd_i", j));
      end
    end

    // Both ports requesting continuously from reset: grants alternate starting with D.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_req = 1; i_addr = 16'h1234; d_req = 1; d_we = 0; d_addr = 16'h5678;
    last_d = 1'b0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(i_ack || d_ack) && n < 30);
      exp_d = !last_d;
      check($sformatf("grant%0d is_d", g), d_ack, exp_d);
      check($sformatf("grant%0d spacing", g), n, Lat + 2);
      if (exp_d) check($sformatf("grant%0d d_rdata", g), d_rdata, 16'hF00D);
      else check($sformatf("grant%0d i_rdata", g), i_rdata, 16'hC0DE);
      last_d = exp_d;
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    @(posedge clk); #1;

    // Abort in the second BUSY cycle; the pending data read follows at normal latency.
    access(1, 0, 16'h0100, 0, 16'hBEEF, 1'b0, "pre_abort");
    ic = i_ack_cnt;
    i_req = 1; i_addr = 16'h0020; d_req = 1; d_we = 0; d_addr = 16'h0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_abort = 1;
    @(negedge clk);
    check("abort busy before", busy, 1);
    @(posedge clk); #1;
    i_abort = 0; i_req = 0;
    @(negedge clk);
    check("abort to idle", busy, 0);
    check("abort i_rdata", i_rdata, 16'hC0DE);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 30);
    check("post-abort d latency", n, Lat + 1);
    check("post-abort d_rdata", d_rdata, 16'hA5C3);
    @(posedge clk); #1;
    d_req = 0;
    @(negedge clk);
    check("abort no i_ack", i_ack_cnt - ic, 0);
    check("abort i_rdata kept", i_rdata, 16'hC0DE);
    @(posedge clk); #1;

    // Abort during the RESP cycle suppresses the ack and keeps i_rdata.
    ic = i_ack_cnt;
    i_req = 1; i_addr = 16'h0020;
    repeat (Lat + 1) @(posedge clk);
    #1 i_abort = 1;
    @(negedge clk);
    check("resp abort i_ack", i_ack, 0);
    check("resp abort i_rdata", i_rdata, 16'hC0DE);
    @(posedge clk); #1;
    i_abort = 0; i_req = 0;
    @(negedge clk);
    check("resp abort idle", busy, 0);
    check("resp abort no ack", i_ack_cnt - ic, 0);
    @(posedge clk); #1;
    access(0, 0, 16'h0020, 0, 16'h9999, 1'b1, "abort_in_idle_read");

    // Reset early in a write, then exactly on the write edge: the old word survives.
    dc = d_ack_cnt;
    d_req = 1; d_we = 1; d_addr = 16'h0030; d_wdata = 16'h1111;
    @(posedge clk); #1;
    rst = 1; d_req = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rst mid i_ack", i_ack, 0);
    check("rst mid d_ack", d_ack, 0);
    check("rst mid i_rdata", i_rdata, 0);
    check("rst mid d_rdata", d_rdata, 0);
    check("rst mid busy", busy, 0);
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_addr = 16'h0030; d_wdata = 16'h3333;
    repeat (Lat) @(posedge clk);
    #1 rst = 1; d_req = 0;
    @(posedge clk); #1;
    rst = 0;
    repeat (8) @(posedge clk);
    #1 check("rst no d_ack", d_ack_cnt - dc, 0);
    access(1, 0, 16'h0030, 0, 16'h2222, 1'b0, "rst_readback");

    // Minimum-latency build: write, then a held read request is served every three cycles.
    l1_d_req = 1; l1_d_we = 1; l1_d_addr = 16'h0040; l1_d_wdata = 16'h5A5A;
    n = 0;
    do begin @(negedge clk); n++; end while (!l1_d_ack && n < 20);
    check("lat1 write latency", n, 3);
    @(posedge clk); #1;
    l1_d_req = 0;
    @(posedge clk); #1;
    l1_d_req = 1; l1_d_we = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("lat1 cycle%0d d_ack", c), l1_d_ack, (c % 3) == 0);
      if (l1_d_ack) check($sformatf("lat1 cycle%0d d_rdata", c), l1_d_rdata, 16'h5A5A);
    end
    @(posedge clk); #1;
    l1_d_req = 0;

    @(posedge clk); #1;
    check("never simultaneous acks", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: ADDR_W, 16, word-address width.
REQ-002 Parameter: LAT, 4, cycles from request capture to ack, legal range 1..15.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst  in  1  reset, synchronous and active-high.
REQ-005 Port: i_req  in  1  fetch request, held high until i_ack.
REQ-006 Port: i_addr  in  ADDR_W  fetch word address, stable while i_req high.
REQ-007 Port: i_abort  in  1  fetch flush (taken branch/jump), single-cycle pulse.
REQ-008 Port: i_ack  out  1  fetch complete, single-cycle pulse.
REQ-009 Port: i_rdata  out  16  fetched instruction, valid while i_ack high and held afterwards.
REQ-010 Port: d_req  in  1  data request, held high until d_ack.
REQ-011 Port: d_we  in  1  data write when high, read when low; stable while d_req high.
REQ-012 Port: d_addr  in  ADDR_W  data word address.
REQ-013 Port: d_wdata  in  16  store data.
REQ-014 Port: d_ack  out  1  data complete, single-cycle pulse.
REQ-015 Port: d_rdata  out  16  load data, valid while d_ack high and held afterwards.
REQ-016 Port: busy  out  1  high in any state other than IDLE; the CPU uses it as its stall source.

Function
REQ-017 The block SHALL serve one access at a time from a single 2^ADDR_W x 16 word array.
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-019 IDLE behaviour:
  - Any request present: capture port, address, we and wdata; load cnt = LAT-1; go to BUSY.
  - No request: remain in IDLE.
REQ-020 Arbitration when i_req and d_req are both high in IDLE:
  - Grant D unless last_grant == D; in that case grant I.
  - last_grant updates on every capture.
REQ-021 BUSY behaviour:
  - cnt != 0: decrement cnt and remain in BUSY.
  - cnt == 0: perform the array access and go to RESP on that edge.
REQ-022 Array access on entry to RESP:
  - Read: rdata of the granted port loads mem[addr].
  - Write: mem[addr] loads wdata; d_rdata is unchanged.
REQ-023 RESP behaviour: assert the granted port's ack for exactly one cycle, then return to IDLE.
REQ-024 Latency: a request captured at edge k SHALL produce ack high in the cycle following edge k+LAT. A new capture is possible no earlier than edge k+LAT+2.
REQ-025 Fetch abort:
  - i_abort high while the captured port is I, in BUSY or RESP: return to IDLE on the next edge and suppress i_ack.
  - The array is unaffected and i_rdata is unchanged.
REQ-026 i_abort SHALL be ignored when the captured port is D or the state is IDLE; an i_req in the same cycle is then still captured.
REQ-027 Captured address, we and wdata are used; input changes after capture SHALL have no effect.
REQ-028 Request dropped before ack (protocol violation): the access SHALL still complete and ack SHALL still pulse.
REQ-029 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-030 On rst sampled high:
  - state = IDLE, cnt = 0, last_grant = I.
  - i_ack = 0, d_ack = 0, i_rdata = 0, d_rdata = 0, busy = 0.
REQ-031 Reset mid-access SHALL abandon the access:
  - No ack is produced.
  - An array write not yet performed SHALL NOT occur.
REQ-032 Array contents SHALL NOT be reset; the bench preloads them.

Structure
REQ-033 Package mem_responder_pkg SHALL hold:
  - The state enum (IDLE/BUSY/RESP).
  - The port enum (PORT_I/PORT_D).
  - Default LAT and data width 16.
REQ-034 The block SHALL contain one sub-module, mem_responder_ram: single-port synchronous array with registered read and write-enable; all control logic stays in mem_responder.

Verification
REQ-035 Read: preload mem[0x0010] = 0xA5C3; d_req = 1, d_we = 0, d_addr = 0x0010 at edge 0 -> d_ack high in the cycle after edge 4, d_rdata = 0xA5C3, busy low from the cycle after edge 5.
REQ-036 Write-then-read: write 0xBEEF to 0x0100, then read 0x0100 -> second d_ack returns 0xBEEF; d_rdata unchanged (0) during the write ack.
REQ-037 Both ports request continuously from reset (i_addr = 0x0000 → 0x1234, d_addr = 0x0001 → 0x5678), acks counted over 4 grants -> grant order D, I, D, I; never simultaneous acks.
REQ-038 Abort: i_req at 0x0020, i_abort pulsed in the 2nd BUSY cycle -> no i_ack, IDLE next edge, i_rdata unchanged; a pending d_req is then served with normal latency.
REQ-039 Reset mid-write: d_we write of 0x1111 to 0x0030 (old value 0x2222), rst high at edge 2 -> no d_ack, mem[0x0030] still 0x2222, all outputs 0.
REQ-040 LAT = 1 build: read request -> ack in the cycle after edge 1; back-to-back requests captured every 3 cycles.
